branch_cond_pipe: RTL and testbench
===================================

Name: branch_cond_pipe

Overview:
- Parametrised, pipelined branch-condition unit; next generation of the single-bit flag comparator.
- Takes two WIDTH-bit operands and a 3-bit condition code, derives N/Z/C/V internally and outputs a 1-bit taken result.
- Two-stage valid/ready pipeline, throughput 1 per cycle; sits between the register-read stage and the branch resolution / PC-select logic.

Parameters:
- WIDTH, 32, operand width in bits (>=2).
- TAG_W, 4, width of the sideband tag passed through unchanged with each operation.
- CNT_W, 16, width of the performance counters (used only with the optional feature).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous pipeline kill
- in_valid  in  1  operation offered
- in_ready  out  1  unit accepts an operation this cycle
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_cond  in  3  condition code
- in_tag  in  TAG_W  sideband tag
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_taken  out  1  condition result
- out_illegal  out  1  in_cond was an unused encoding
- out_tag  out  TAG_W  tag of the result

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low. While rst_n=0, all valid bits, out_taken, out_illegal and out_tag are 0, and in_ready is 1 on the first cycle after release.
- Condition codes:
  - 000 EQ, 001 NE, 100 LT (signed), 101 GE (signed), 110 LTU, 111 GEU.
  - 010 and 011 are illegal: out_taken=0, out_illegal=1.
- Stage 1 (on accept):
  - Compute {C, D} = in_a + ~in_b + 1, using a WIDTH+1 bit sum.
  - N = D[WIDTH-1].
  - Z = (D == 0).
  - V = (in_a[MSB] != in_b[MSB]) & (D[MSB] != in_a[MSB]).
  - Register N, Z, C, V together with cond and tag.
- Stage 2: evaluate the condition.
  - LT = N ^ V, GE = ~LT.
  - LTU = ~C, GEU = C.
  - EQ = Z, NE = ~Z.
  - Register the result into the out_* outputs.
- Handshake:
  - s2_adv = !s2_valid | out_ready.
  - s1_adv = !s1_valid | s2_adv.
  - in_ready = s1_adv. in_ready depends combinationally on out_ready; there is no other combinational in-to-out path.
  - A transfer occurs when valid & ready are both high.
  - Latency is 2 cycles from input accept to out_valid when there is no stall.
  - While out_valid=1 and out_ready=0, out_taken, out_illegal and out_tag hold stable.
- Flush:
  - On the next edge, both stage valid bits clear.
  - An input offered in the same cycle as flush is discarded.
  - out_valid is 0 the cycle after flush.
  - Flush has priority over every advance.
- Boundaries:
  - Full pipeline with out_ready=0: in_ready=0, nothing is lost.
  - Output handshake and input accept in the same cycle: both stages advance and throughput is kept.
  - Operands equal to 0 or to all-ones are covered by the flag equations; there are no special cases.
  - Reset asserted mid-operation drops all in-flight results immediately.

Optional Feature:
- Macro: BRANCH_COND_PERF_EN.
- Defined:
  - Adds outputs perf_taken (CNT_W) and perf_total (CNT_W).
  - On each output handshake, perf_total increments; perf_taken also increments when out_taken=1.
  - Both counters saturate at all-ones and clear on rst_n.
  - Flushed operations are not counted.
- Undefined: the ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- WIDTH=32, a=0xFFFFFFFF, b=0x00000001, in_cond LT then LTU, out_ready=1 -> taken=1 then 0; each appears 2 cycles after its accept.
- a=0x80000000, b=0x7FFFFFFF, GE (signed overflow case) -> taken=0; same operands with GEU -> taken=1.
- a=b=0x1234, EQ/NE/GEU/LT back-to-back on 4 consecutive cycles -> results 1,0,1,0 on 4 consecutive cycles, tags in order.
- in_cond=010 -> out_illegal=1, taken=0; the next legal operation has out_illegal=0.
- Fill the pipeline with out_ready=0 -> in_ready=0 after 2 accepts, outputs held; raise out_ready -> both results drain in order, with no loss or duplication.
- Flush with both stages valid and in_valid=1 -> out_valid=0 the next cycle and no results appear. Also assert rst_n=0 mid-stream -> all outputs 0 asynchronously. With BRANCH_COND_PERF_EN, counters match the handshaked totals.

Source files
------------

// File: rtl/branch_cond_pipe.sv
// branch_cond_pipe: two-stage valid/ready branch-condition unit.
// Stage 1 subtracts the operands and registers the N/Z/C/V flags.
// Stage 2 evaluates the condition code against those flags and
// registers the taken/illegal result.
// Optional: define BRANCH_COND_PERF_EN to add saturating perf counters
// (perf_total, perf_taken) that count output handshakes.
module branch_cond_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_cond,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_taken,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
`ifdef BRANCH_COND_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_taken,
  output logic [CNT_W-1:0] perf_total
`endif
);

  // Elaboration-time sanity on the parameters.
  if (WIDTH < 2) begin : g_bad_width
    $error("branch_cond_pipe: WIDTH must be >= 2");
  end
  if (CNT_W < 1) begin : g_bad_cnt
    $error("branch_cond_pipe: CNT_W must be >= 1");
  end

  // Stage-1 payload: flags plus the fields stage 2 still needs.
  typedef struct packed {
    logic             n;
    logic             z;
    logic             c;
    logic             v;
    logic [2:0]       cond;
    logic [TAG_W-1:0] tag;
  } s1_t;

  logic [2:1]   r_vld;
  s1_t          r_s1;
  s1_t          w_s1;
  logic [WIDTH:0] w_sum;
  logic         w_s1_adv;
  logic         w_s2_adv;
  logic         w_lt;
  logic         w_taken;
  logic         w_illegal;

  assign w_s2_adv  = !r_vld[2] | out_ready;
  assign w_s1_adv  = !r_vld[1] | w_s2_adv;
  assign in_ready  = w_s1_adv;
  assign out_valid = r_vld[2];

  // a - b as a + ~b + 1; the extra bit is the no-borrow carry.
  assign w_sum = {1'b0, in_a} + {1'b0, ~in_b} + {{WIDTH{1'b0}}, 1'b1};

  // Flag derivation for the incoming operation.
  always_comb begin
    w_s1      = '0;
    w_s1.n    = w_sum[WIDTH-1];
    w_s1.z    = (w_sum[WIDTH-1:0] == '0);
    w_s1.c    = w_sum[WIDTH];
    w_s1.v    = (in_a[WIDTH-1] != in_b[WIDTH-1]) & (w_sum[WIDTH-1] != in_a[WIDTH-1]);
    w_s1.cond = in_cond;
    w_s1.tag  = in_tag;
  end

  // Condition evaluation from the registered flags.
  always_comb begin
    w_lt      = r_s1.n ^ r_s1.v;
    w_taken   = 1'b0;
    w_illegal = 1'b0;
    case (r_s1.cond)
      3'b000:  w_taken = r_s1.z;
      3'b001:  w_taken = ~r_s1.z;
      3'b100:  w_taken = w_lt;
      3'b101:  w_taken = ~w_lt;
      3'b110:  w_taken = ~r_s1.c;
      3'b111:  w_taken = r_s1.c;
      default: w_illegal = 1'b1;
    endcase
  end

  // Valid bits; flush wins over any advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
    end else if (flush) begin
      r_vld <= '0;
    end else begin
      if (w_s1_adv) r_vld[1] <= in_valid;
      if (w_s2_adv) r_vld[2] <= r_vld[1];
    end
  end

  // Stage-1 payload loads only with a real accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    r_s1 <= '0;
    else if (w_s1_adv && in_valid) r_s1 <= w_s1;
  end

  // Output registers hold while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_taken   <= 1'b0;
      out_illegal <= 1'b0;
      out_tag     <= '0;
    end else if (w_s2_adv && r_vld[1]) begin
      out_taken   <= w_taken;
      out_illegal <= w_illegal;
      out_tag     <= r_s1.tag;
    end
  end

`ifdef BRANCH_COND_PERF_EN
  logic w_out_xfer;
  assign w_out_xfer = out_valid & out_ready & ~flush;

  // Saturating handshake counters; flushed work never counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_total <= '0;
      perf_taken <= '0;
    end else if (w_out_xfer) begin
      if (perf_total != '1)              perf_total <= perf_total + 1'b1;
      if (out_taken && perf_taken != '1) perf_taken <= perf_taken + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_cond_pipe.sv
// Randomized + directed bench for branch_cond_pipe against a queue-based
// reference model using plain signed/unsigned comparisons.
module tb_branch_cond_pipe;
  localparam int WIDTH = 32;
  localparam int TAG_W = 4;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [2:0]       in_cond;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic             out_taken;
  logic             out_illegal;
  logic [TAG_W-1:0] out_tag;
`ifdef BRANCH_COND_PERF_EN
  logic [CNT_W-1:0] perf_taken;
  logic [CNT_W-1:0] perf_total;
`endif

  branch_cond_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cond(in_cond), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_taken(out_taken), .out_illegal(out_illegal), .out_tag(out_tag)
`ifdef BRANCH_COND_PERF_EN
    , .perf_taken(perf_taken), .perf_total(perf_total)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int               cyc;
    logic             taken;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  int   m_total = 0;
  int   m_taken = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: branch decision straight from the comparison semantics.
  task automatic ref_eval(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [2:0] c, output logic t, output logic ill);
    t = 1'b0; ill = 1'b0;
    case (c)
      3'd0: t = (a == b);
      3'd1: t = (a != b);
      3'd4: t = ($signed(a) <  $signed(b));
      3'd5: t = ($signed(a) >= $signed(b));
      3'd6: t = (a <  b);
      3'd7: t = (a >= b);
      default: ill = 1'b1;
    endcase
  endtask

  // One clock: drive after the edge, check mid-cycle, advance the model.
  task automatic step(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic [2:0] c, input logic [TAG_W-1:0] t,
                      input logic ordy, input logic fl);
    logic exp_rdy, exp_ov;
    exp_t e;
    @(posedge clk); #1;
    in_valid = v; in_a = a; in_b = b; in_cond = c; in_tag = t;
    out_ready = ordy; flush = fl;
    cyc++;
    @(negedge clk);
    exp_rdy = !(q.size() == 2 && !ordy);
    exp_ov  = (q.size() > 0) && (cyc >= q[0].cyc + 2);
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    chk("out_valid", 64'(out_valid), 64'(exp_ov));
    if (exp_ov)
      chk("out_data", 64'({out_taken, out_illegal, out_tag}),
          64'({q[0].taken, q[0].ill, q[0].tag}));
    if (fl) begin
      q.delete();
    end else begin
      if (exp_ov && ordy) begin
        m_total++;
        if (q[0].taken) m_taken++;
        void'(q.pop_front());
      end
      if (v && exp_rdy) begin
        e.cyc = cyc; e.tag = t;
        ref_eval(a, b, c, e.taken, e.ill);
        q.push_back(e);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 3'd0, '0, 1'b1, 1'b0);
  endtask

  task automatic rand_run(input int n);
    logic [WIDTH-1:0] a, b;
    for (int i = 0; i < n; i++) begin
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 3))
        0: b = a;
        1: b = a ^ (32'h1 << $urandom_range(0, 31));
        2: a = ($urandom_range(0, 1) != 0) ? '1 : 32'h8000_0000;
        default: ;
      endcase
      step($urandom_range(0, 3) != 0, a, b, 3'($urandom), 4'($urandom),
           $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
    end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_cond = '0; in_tag = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_taken", 64'(out_taken), 64'd0);
    chk("rst_out_illegal", 64'(out_illegal), 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    rst_n = 1'b1;

    // Signed vs unsigned on -1 / 1.
    step(1'b1, 32'hFFFF_FFFF, 32'h1, 3'd4, 4'd1, 1'b1, 1'b0);
    step(1'b1, 32'hFFFF_FFFF, 32'h1, 3'd6, 4'd2, 1'b1, 1'b0);
    idle(3);
    // Signed overflow case.
    step(1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 3'd5, 4'd3, 1'b1, 1'b0);
    step(1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 3'd7, 4'd4, 1'b1, 1'b0);
    idle(3);
    // Back-to-back equal operands.
    step(1'b1, 32'h1234, 32'h1234, 3'd0, 4'd5, 1'b1, 1'b0);
    step(1'b1, 32'h1234, 32'h1234, 3'd1, 4'd6, 1'b1, 1'b0);
    step(1'b1, 32'h1234, 32'h1234, 3'd7, 4'd7, 1'b1, 1'b0);
    step(1'b1, 32'h1234, 32'h1234, 3'd4, 4'd8, 1'b1, 1'b0);
    idle(3);
    // Illegal code followed by a legal one.
    step(1'b1, 32'h5, 32'h5, 3'd2, 4'd9, 1'b1, 1'b0);
    step(1'b1, 32'h5, 32'h5, 3'd0, 4'd10, 1'b1, 1'b0);
    idle(3);
    // Fill with the consumer stalled, then drain.
    for (int i = 0; i < 5; i++)
      step(1'b1, 32'(i), 32'd2, 3'd6, 4'(11 + i), 1'b0, 1'b0);
    idle(4);
    // Flush with both stages full and an input offered.
    step(1'b1, 32'h0, 32'h0, 3'd0, 4'd1, 1'b0, 1'b0);
    step(1'b1, 32'h0, 32'h1, 3'd1, 4'd2, 1'b0, 1'b0);
    step(1'b1, 32'h3, 32'h1, 3'd5, 4'd3, 1'b0, 1'b1);
    idle(4);

    rand_run(1500);

    // Asynchronous reset mid-stream.
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_out_taken", 64'(out_taken), 64'd0);
    chk("arst_out_illegal", 64'(out_illegal), 64'd0);
    chk("arst_out_tag", 64'(out_tag), 64'd0);
    in_valid = 1'b0; flush = 1'b0;
    q.delete();
`ifdef BRANCH_COND_PERF_EN
    chk("arst_perf_total", 64'(perf_total), 64'd0);
    chk("arst_perf_taken", 64'(perf_taken), 64'd0);
    m_total = 0; m_taken = 0;
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;

    rand_run(1500);
    idle(4);
`ifdef BRANCH_COND_PERF_EN
    chk("perf_total", 64'(perf_total), 64'(m_total));
    chk("perf_taken", 64'(perf_taken), 64'(m_taken));
`endif
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
